// File: rtl/rhs_stim_pkg.sv
// Shared types and helpers for the RHS2116 biphasic stimulation sequencer:
// FSM state encoding, chip register addresses and the WRITE lane-word builder.
package rhs_stim_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POL1,
    ST_ON,
    ST_PH1,
    ST_POL2,
    ST_PH2,
    ST_OFF,
    ST_REC_ON,
    ST_REC_WAIT,
    ST_REC_OFF,
    ST_GAP,
    ST_DONE
  } stim_state_e;

  localparam logic [7:0] REG_ON  = 8'h2A;
  localparam logic [7:0] REG_POL = 8'h2C;
  localparam logic [7:0] REG_REC = 8'h2E;

  // WRITE header: 2'b10, U=1 (latch on next update), M=0.
  localparam logic [3:0] CMD_HDR = 4'b1010;

  function automatic logic [31:0] lane_word(input logic [7:0] reg_addr,
                                            input logic [15:0] data);
    return {CMD_HDR, 4'b0000, reg_addr, data};
  endfunction

endpackage

// File: rtl/rhs_tick_gen.sv
// 50 us tick prescaler with restart, plus a tick-count comparator that flags
// the last cycle of a window of 'target' ticks.
module rhs_tick_gen #(
  parameter int TICK_DIV = 2800,
  parameter int CNT_W    = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             restart,
  input  logic             run,
  input  logic [CNT_W-1:0] target,
  output logic             expire
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  assign tick   = run && (pre_cnt == PRE_MAX);
  // Target is never 0 while running, so target-1 is the index of the final tick.
  assign expire = tick && (tick_cnt == target - CNT_W'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pre_cnt  <= '0;
      tick_cnt <= '0;
    end else if (restart) begin
      pre_cnt  <= '0;
      tick_cnt <= '0;
    end else if (tick) begin
      pre_cnt  <= '0;
      tick_cnt <= tick_cnt + CNT_W'(1);
    end else if (run) begin
      pre_cnt  <= pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/rhs_stim_sequencer.sv
// Biphasic stimulation sequencer for one or two RHS2116 chips; emits per-lane
// WRITE command words. Optional charge recovery: RHS_STIM_CHARGE_RECOVERY_EN.
module rhs_stim_sequencer
  import rhs_stim_pkg::*;
#(
  parameter int NUM_CH   = 32,
  parameter int TICK_DIV = 2800,
  parameter int PW_W     = 16,
  parameter int DLY_W    = 16,
  parameter int CNT_W    = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NUM_CH-1:0]        cfg_pos_mask,
  input  logic [NUM_CH-1:0]        cfg_neg_mask,
  input  logic                     cfg_first_b,
  input  logic [PW_W-1:0]          cfg_pw,
  input  logic [DLY_W-1:0]         cfg_gap,
  input  logic [CNT_W-1:0]         cfg_npulse,
  input  logic                     cfg_infinite,
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
  input  logic [DLY_W-1:0]         cfg_rec,
`endif
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [32*NUM_CH/16-1:0]  cmd_word,
  output logic                     busy,
  output logic                     stim_active,
  output logic                     done,
  output logic                     aborted,
  output logic                     err,
  output logic [CNT_W-1:0]         pulse_count
);

  localparam int NUM_LANE = NUM_CH / 16;
  localparam int TW       = (PW_W > DLY_W) ? PW_W : DLY_W;

  stim_state_e state, next_state;

  logic [NUM_CH-1:0] pos_q, neg_q;
  logic              first_b_q, inf_q, abort_q;
  logic [PW_W-1:0]   pw_q;
  logic [DLY_W-1:0]  gap_q;
  logic [CNT_W-1:0]  npulse_q;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
  logic [DLY_W-1:0]  rec_q;
  logic              last_q;
`endif

  logic              hs, abort_hit, mask_ok, last_now;
  logic              start_ok, start_bad, pulse_inc, abort_exit;
  logic              timed_run, expire;
  logic [TW-1:0]     timed_target;
  logic [PW_W-1:0]   pw_eff;
  logic [NUM_CH-1:0] on_data, pol_a, pol_b, lane_data;
  logic [7:0]        reg_sel;
  stim_state_e       resume_state;

  assign mask_ok = ((cfg_pos_mask & cfg_neg_mask) == '0) &&
                   ((cfg_pos_mask | cfg_neg_mask) != '0);

  assign cmd_valid   = (state == ST_POL1) || (state == ST_ON) || (state == ST_POL2) ||
                       (state == ST_OFF) || (state == ST_REC_ON) || (state == ST_REC_OFF);
  assign hs          = cmd_valid && cmd_ready;
  assign abort_hit   = abort || abort_q;
  assign busy        = (state != ST_IDLE);
  assign stim_active = (state == ST_PH1) || (state == ST_PH2);
  assign timed_run   = stim_active || (state == ST_GAP) || (state == ST_REC_WAIT);

  assign last_now     = !inf_q && (pulse_count == npulse_q);
  assign resume_state = (gap_q != '0) ? ST_GAP : ST_POL1;
  assign pw_eff       = (pw_q == '0) ? PW_W'(1) : pw_q;

  assign on_data = pos_q | neg_q;
  assign pol_a   = pos_q;
  assign pol_b   = ~pos_q & on_data;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    timed_target = '0;
    case (state)
      ST_PH1, ST_PH2: timed_target = TW'(pw_eff);
      ST_GAP:         timed_target = TW'(gap_q);
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
      ST_REC_WAIT:    timed_target = TW'(rec_q);
`endif
      default:        timed_target = '0;
    endcase
  end

  // Every timed window starts from the handshake that precedes it.
  rhs_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (TW)
  ) u_tick_gen (
    .aclk    (aclk),
    .aresetn (aresetn),
    .restart (hs),
    .run     (timed_run),
    .target  (timed_target),
    .expire  (expire)
  );

  always_comb begin
    reg_sel   = REG_ON;
    lane_data = '0;
    case (state)
      ST_POL1: begin
        reg_sel   = REG_POL;
        lane_data = first_b_q ? pol_b : pol_a;
      end
      ST_POL2: begin
        reg_sel   = REG_POL;
        lane_data = first_b_q ? pol_a : pol_b;
      end
      ST_ON:      lane_data = on_data;
      ST_REC_ON: begin
        reg_sel   = REG_REC;
        lane_data = on_data;
      end
      ST_REC_OFF: reg_sel = REG_REC;
      default: begin
        reg_sel   = REG_ON;
        lane_data = '0;
      end
    endcase
  end

  for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
    assign cmd_word[32*k +: 32] = cmd_valid ? lane_word(reg_sel, lane_data[16*k +: 16]) : 32'h0;
  end

  always_comb begin
    next_state = state;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    pulse_inc  = 1'b0;
    abort_exit = 1'b0;
    if (start && state != ST_IDLE) start_bad = 1'b1;
    case (state)
      ST_IDLE: if (start) begin
        if (mask_ok) begin
          start_ok   = 1'b1;
          next_state = ST_POL1;
        end else begin
          start_bad  = 1'b1;
        end
      end
      ST_POL1: if (hs) next_state = abort_hit ? ST_OFF : ST_ON;
      ST_ON:   if (hs) next_state = abort_hit ? ST_OFF : ST_PH1;
      ST_PH1:  if (abort) next_state = ST_OFF; else if (expire) next_state = ST_POL2;
      ST_POL2: if (hs) next_state = abort_hit ? ST_OFF : ST_PH2;
      ST_PH2:  if (abort || expire) next_state = ST_OFF;
      ST_OFF: if (hs) begin
        if (abort_hit) begin
          next_state = ST_IDLE;
          abort_exit = 1'b1;
        end else begin
          pulse_inc  = 1'b1;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
          if (rec_q != '0) next_state = ST_REC_ON;
          else             next_state = last_now ? ST_DONE : resume_state;
`else
          next_state = last_now ? ST_DONE : resume_state;
`endif
        end
      end
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
      ST_REC_ON:   if (hs) next_state = abort_hit ? ST_REC_OFF : ST_REC_WAIT;
      ST_REC_WAIT: if (abort || expire) next_state = ST_REC_OFF;
      ST_REC_OFF: if (hs) begin
        if (abort_hit) begin
          next_state = ST_IDLE;
          abort_exit = 1'b1;
        end else begin
          next_state = last_q ? ST_DONE : resume_state;
        end
      end
`endif
      ST_GAP:  if (abort) next_state = ST_OFF; else if (expire) next_state = ST_POL1;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      pos_q       <= '0;
      neg_q       <= '0;
      first_b_q   <= 1'b0;
      inf_q       <= 1'b0;
      pw_q        <= '0;
      gap_q       <= '0;
      npulse_q    <= '0;
      abort_q     <= 1'b0;
      pulse_count <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      err         <= 1'b0;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
      rec_q       <= '0;
      last_q      <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (start_ok) begin
        pos_q       <= cfg_pos_mask;
        neg_q       <= cfg_neg_mask;
        first_b_q   <= cfg_first_b;
        inf_q       <= cfg_infinite;
        pw_q        <= cfg_pw;
        gap_q       <= cfg_gap;
        npulse_q    <= cfg_npulse;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
        rec_q       <= cfg_rec;
`endif
        abort_q     <= 1'b0;
        pulse_count <= '0;
        done        <= 1'b0;
        aborted     <= 1'b0;
        err         <= 1'b0;
      end else begin
        if (start_bad) err <= 1'b1;
        if (abort && state != ST_IDLE) abort_q <= 1'b1;
        // Returning to IDLE retires any abort request, including one that lands in DONE.
        if (next_state == ST_IDLE) abort_q <= 1'b0;
        if (pulse_inc) pulse_count <= pulse_count + CNT_W'(1);
        if (state == ST_DONE) done <= 1'b1;
        if (abort_exit) aborted <= 1'b1;
      end
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
      if (state == ST_OFF && hs) last_q <= last_now;
`endif
    end
  end

endmodule

// File: tb/tb_rhs_stim_sequencer.sv
// Randomized self-checking bench for rhs_stim_sequencer: a pulse-level model
// predicts the command stream and the gap (in cycles) before each command.
module tb_rhs_stim_sequencer;

  localparam int NUM_CH = 32;
  localparam int TD     = 4;
  localparam int BUDGET = 5000;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_pos_mask = '0;
  logic [31:0] cfg_neg_mask = '0;
  logic        cfg_first_b = 1'b0;
  logic [15:0] cfg_pw = '0;
  logic [15:0] cfg_gap = '0;
  logic [15:0] cfg_npulse = '0;
  logic        cfg_infinite = 1'b0;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
  logic [15:0] cfg_rec = '0;
`endif
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [63:0] cmd_word;
  logic        busy, stim_active, done, aborted, err;
  logic [15:0] pulse_count;

  always #5 aclk = ~aclk;

  rhs_stim_sequencer #(
    .NUM_CH   (NUM_CH),
    .TICK_DIV (TD)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .start        (start),
    .abort        (abort),
    .cfg_pos_mask (cfg_pos_mask),
    .cfg_neg_mask (cfg_neg_mask),
    .cfg_first_b  (cfg_first_b),
    .cfg_pw       (cfg_pw),
    .cfg_gap      (cfg_gap),
    .cfg_npulse   (cfg_npulse),
    .cfg_infinite (cfg_infinite),
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
    .cfg_rec      (cfg_rec),
`endif
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_word     (cmd_word),
    .busy         (busy),
    .stim_active  (stim_active),
    .done         (done),
    .aborted      (aborted),
    .err          (err),
    .pulse_count  (pulse_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] word;
    int          delay;
  } cmd_t;

  cmd_t got_q[$];
  cmd_t exp_q[$];
  cmd_t mon_e;
  int   exp_pulses;

  // Monitor on the falling edge: records each handshake with the number of
  // cycles between the previous handshake (or start) and the command's first valid cycle.
  int          cyc = 0, ref_cyc = 0, hs_cnt = 0, cur_delay = 0;
  logic        prev_pend = 1'b0;
  logic [63:0] prev_word = '0;

  always @(negedge aclk) begin
    cyc++;
    if (!aresetn) begin
      prev_pend = 1'b0;
      ref_cyc   = cyc;
    end else begin
      if (prev_pend) begin
        check("valid_hold", cmd_valid, 1'b1);
        check("word_hold", cmd_word, prev_word);
      end else if (cmd_valid) begin
        cur_delay = cyc - ref_cyc;
      end
      if (start && !busy) ref_cyc = cyc;
      if (cmd_valid && cmd_ready) begin
        mon_e.word  = cmd_word;
        mon_e.delay = cur_delay;
        got_q.push_back(mon_e);
        ref_cyc = cyc;
        hs_cnt++;
      end
      prev_pend = cmd_valid && !cmd_ready;
      prev_word = cmd_word;
    end
  end

  // cmd_ready: 0 = always ready, 1 = random back-pressure, 2 = 10-cycle stall on the third command.
  int ready_mode = 0;
  int stall_n    = 0;

  always @(posedge aclk) begin
    #1;
    case (ready_mode)
      1: cmd_ready = ($urandom_range(0, 3) != 0);
      2: if (cmd_valid && hs_cnt == 2 && stall_n < 10) begin
           cmd_ready = 1'b0;
           stall_n++;
         end else begin
           cmd_ready = 1'b1;
         end
      default: cmd_ready = 1'b1;
    endcase
  end

  function automatic logic [63:0] mk(input logic [7:0] r, input logic [31:0] d);
    return {8'hA0, r, d[31:16], 8'hA0, r, d[15:0]};
  endfunction

  task automatic push_exp(input logic [63:0] w, input int d);
    cmd_t e;
    e.word  = w;
    e.delay = d;
    exp_q.push_back(e);
  endtask

  // Pulse-level model: polarity, ON, polarity, OFF per pulse; phases are pw*TD cycles.
  task automatic build_model(input int abort_pulse);
    logic [31:0] on_m, p1, p2;
    int t_ph, lead, n;
    exp_q.delete();
    on_m = cfg_pos_mask | cfg_neg_mask;
    p1   = cfg_first_b ? (on_m & ~cfg_pos_mask) : cfg_pos_mask;
    p2   = cfg_first_b ? cfg_pos_mask : (on_m & ~cfg_pos_mask);
    t_ph = ((cfg_pw == 0) ? 1 : int'(cfg_pw)) * TD;
    lead = 1;
    n    = 0;
    while (n < 1000) begin
      push_exp(mk(8'h2C, p1), lead);
      push_exp(mk(8'h2A, on_m), 1);
      if (abort_pulse == n + 1) begin
        push_exp(mk(8'h2A, 32'h0), -1);
        break;
      end
      push_exp(mk(8'h2C, p2), 1 + t_ph);
      push_exp(mk(8'h2A, 32'h0), 1 + t_ph);
      n++;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
      if (cfg_rec != 0) begin
        push_exp(mk(8'h2E, on_m), 1);
        push_exp(mk(8'h2E, 32'h0), 1 + int'(cfg_rec) * TD);
      end
`endif
      if (!cfg_infinite && n == int'(cfg_npulse) + 1) break;
      lead = (cfg_gap != 0) ? 1 + int'(cfg_gap) * TD : 1;
    end
    exp_pulses = n;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic run_seq(input string name, input int abort_pulse, input int ready_m);
    int budget, per;
    per = 4;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
    if (cfg_rec != 0) per = 6;
`endif
    build_model(abort_pulse);
    got_q.delete();
    hs_cnt     = 0;
    stall_n    = 0;
    ready_mode = ready_m;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    // Inputs are latched at start; scrambling them must not affect the run.
    cfg_pos_mask = $urandom;
    cfg_neg_mask = $urandom;
    cfg_pw       = 16'($urandom);
    cfg_gap      = 16'($urandom);
    cfg_npulse   = 16'($urandom);
    cfg_first_b  = 1'($urandom);
    cfg_infinite = 1'($urandom);
    if (abort_pulse > 0) begin
      budget = 0;
      while (!(hs_cnt == (abort_pulse - 1) * per + 2 && stim_active) && budget < BUDGET) begin
        tick(1);
        budget++;
      end
      check({name, "_abort_window"}, budget < BUDGET, 1'b1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
    end
    budget = 0;
    while (busy && budget < BUDGET) begin
      tick(1);
      budget++;
    end
    check({name, "_busy_end"}, busy, 1'b0);
    check({name, "_ncmd"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_word%0d", name, i), got_q[i].word, exp_q[i].word);
      if (exp_q[i].delay >= 0)
        check($sformatf("%s_dly%0d", name, i), got_q[i].delay, exp_q[i].delay);
    end
    check({name, "_done"}, done, abort_pulse == 0);
    check({name, "_aborted"}, aborted, abort_pulse != 0);
    check({name, "_err"}, err, 1'b0);
    check({name, "_pcount"}, pulse_count, exp_pulses);
    check({name, "_valid_idle"}, cmd_valid, 1'b0);
    tick(2);
  endtask

  task automatic set_base_cfg();
    cfg_pos_mask = 32'h1 << 17;
    cfg_neg_mask = 32'h1 << 18;
    cfg_first_b  = 1'b0;
    cfg_pw       = 16'd1;
    cfg_gap      = 16'd16;
    cfg_npulse   = 16'd1;
    cfg_infinite = 1'b0;
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
    cfg_rec      = 16'd0;
`endif
  endtask

  initial begin
    int budget, ap;
    aresetn = 1'b0;
    tick(3);
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_word", cmd_word, 64'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_stim", stim_active, 1'b0);
    check("rst_flags", {done, aborted, err}, 3'b000);
    check("rst_pcount", pulse_count, 16'h0);
    aresetn = 1'b1;
    tick(2);

    set_base_cfg();
    run_seq("t1", 0, 0);

    set_base_cfg();
    run_seq("t2_stall", 0, 2);

    // Rejected starts: overlapping masks, then empty masks.
    cfg_pos_mask = 32'h1;
    cfg_neg_mask = 32'h1;
    got_q.delete();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(20);
    check("t3_err", err, 1'b1);
    check("t3_busy", busy, 1'b0);
    check("t3_ncmd", got_q.size(), 0);
    cfg_pos_mask = 32'h0;
    cfg_neg_mask = 32'h0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    check("t3b_err", err, 1'b1);
    check("t3b_ncmd", got_q.size(), 0);

    set_base_cfg();
    cfg_infinite = 1'b1;
    run_seq("t4_abort", 3, 0);
    set_base_cfg();
    cfg_infinite = 1'b1;
    cfg_first_b  = 1'b1;
    run_seq("t4b_abort", 2, 1);

    // Reset in the second pulse's PH2.
    set_base_cfg();
    cfg_gap    = 16'd1;
    cfg_npulse = 16'd3;
    hs_cnt = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    budget = 0;
    while (!(hs_cnt == 7 && stim_active) && budget < BUDGET) begin
      tick(1);
      budget++;
    end
    check("t5_reach_ph2", budget < BUDGET, 1'b1);
    check("t5_pcount_pre", pulse_count, 16'd1);
    aresetn = 1'b0;
    #1;
    check("t5_valid", cmd_valid, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_stim", stim_active, 1'b0);
    check("t5_pcount", pulse_count, 16'd0);
    tick(2);
    aresetn = 1'b1;
    tick(2);
    set_base_cfg();
    run_seq("t5_after", 0, 1);

`ifdef RHS_STIM_CHARGE_RECOVERY_EN
    set_base_cfg();
    cfg_rec = 16'd2;
    run_seq("t6_rec", 0, 0);
`endif

    for (int it = 0; it < 14; it++) begin
      cfg_pos_mask = $urandom;
      if ($urandom_range(0, 1) == 1) cfg_pos_mask = cfg_pos_mask & $urandom & $urandom;
      cfg_neg_mask = $urandom & ~cfg_pos_mask;
      if ((cfg_pos_mask | cfg_neg_mask) == 32'h0) cfg_pos_mask = 32'h1;
      cfg_first_b  = 1'($urandom);
      cfg_pw       = 16'($urandom_range(0, 3));
      cfg_gap      = 16'($urandom_range(0, 3));
      cfg_npulse   = 16'($urandom_range(0, 3));
      cfg_infinite = ($urandom_range(0, 3) == 0);
`ifdef RHS_STIM_CHARGE_RECOVERY_EN
      cfg_rec      = 16'($urandom_range(0, 2));
`endif
      ap = cfg_infinite ? $urandom_range(1, 3) : 0;
      run_seq($sformatf("rnd%0d", it), ap, $urandom_range(0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
